// File: rtl/router_egress_arb_pkg.sv
// Shared definitions for the router egress arbiter: state encoding, header
// field layout and grant encodings.
package router_egress_arb_pkg;

    localparam int unsigned DATA_W    = 8;
    localparam int unsigned LEN_W     = 6;
    localparam int unsigned NUM_PORTS = 3;

    // Header byte layout: {len[5:0], addr[1:0]}
    localparam int unsigned ADDR_LSB = 0;
    localparam int unsigned LEN_LSB  = 2;

    // Remaining counter covers payload plus the trailing parity beat.
    localparam int unsigned REM_W = LEN_W + 1;

    localparam logic [1:0] IDLE_GRANT = 2'b11;
    // Last-served pointer after reset, so FIFO 0 is the first candidate.
    localparam logic [1:0] RR_RESET   = 2'd2;

    typedef enum logic [1:0] {
        StIdle,
        StHeader,
        StBody
    } arb_state_e;

    function automatic logic [LEN_W-1:0] hdr_len(input logic [DATA_W-1:0] hdr);
        return hdr[LEN_LSB +: LEN_W];
    endfunction

endpackage

// File: rtl/router_egress_arb_if.sv
// Egress valid/ready link carrying packet beats with framing and abort marks.
interface router_egress_arb_if;
    import router_egress_arb_pkg::*;

    logic [DATA_W-1:0] data;
    logic              valid;
    logic              ready;
    logic              sop;
    logic              eop;
    logic              abort;

    modport master (
        output data,
        output valid,
        output sop,
        output eop,
        output abort,
        input  ready
    );

    modport slave (
        input  data,
        input  valid,
        input  sop,
        input  eop,
        input  abort,
        output ready
    );

endinterface

// File: rtl/router_egress_arb_rr_pick.sv
// Combinational 3-way round-robin picker: first requester after 'last',
// wrapping 0 -> 1 -> 2 -> 0.
module router_rr_pick
    import router_egress_arb_pkg::*;
(
    input  logic [NUM_PORTS-1:0] req,
    input  logic [1:0]           last,
    output logic                 gnt_valid,
    output logic [1:0]           gnt_idx
);

    logic [1:0] first_idx;
    logic [1:0] second_idx;
    logic [1:0] third_idx;

    // Rotate the search order so the port after 'last' is tried first.
    always_comb begin : pick_order
        case (last)
            2'd0: begin
                first_idx  = 2'd1;
                second_idx = 2'd2;
                third_idx  = 2'd0;
            end
            2'd1: begin
                first_idx  = 2'd2;
                second_idx = 2'd0;
                third_idx  = 2'd1;
            end
            // last == 2, or the unused code 3, restarts at port 0
            default: begin
                first_idx  = 2'd0;
                second_idx = 2'd1;
                third_idx  = 2'd2;
            end
        endcase
    end

    // Priority select along the rotated order.
    always_comb begin : pick_select
        gnt_valid = 1'b0;
        gnt_idx   = 2'd0;
        if (req[first_idx]) begin
            gnt_valid = 1'b1;
            gnt_idx   = first_idx;
        end else if (req[second_idx]) begin
            gnt_valid = 1'b1;
            gnt_idx   = second_idx;
        end else if (req[third_idx]) begin
            gnt_valid = 1'b1;
            gnt_idx   = third_idx;
        end
    end

endmodule

// File: rtl/router_egress_arb.sv
// Packet-atomic round-robin scheduler draining three router FIFOs onto one
// valid/ready egress link. A granted FIFO keeps the link for header, payload
// and parity; the header length field sizes the packet.
module router_egress_arb
    import router_egress_arb_pkg::*;
(
    input  logic                clock,
    input  logic                resetn,
    input  logic                fifo_empty_0,
    input  logic                fifo_empty_1,
    input  logic                fifo_empty_2,
    input  logic [DATA_W-1:0]   fifo_dout_0,
    input  logic [DATA_W-1:0]   fifo_dout_1,
    input  logic [DATA_W-1:0]   fifo_dout_2,
    input  logic                soft_reset_0,
    input  logic                soft_reset_1,
    input  logic                soft_reset_2,
    output logic                read_enb_0,
    output logic                read_enb_1,
    output logic                read_enb_2,
    output logic [1:0]          grant,
    router_egress_arb_if.master egress
);

    arb_state_e        state_q, state_d;
    logic [1:0]        rr_ptr_q, rr_ptr_d;
    logic [1:0]        grant_q, grant_d;
    logic [REM_W-1:0]  remaining_q, remaining_d;
    logic              valid_q, valid_d;
    logic              sop_q, sop_d;
    logic              eop_q, eop_d;
    logic              abort_q, abort_d;

    logic [NUM_PORTS-1:0] req;
    logic                 pick_valid;
    logic [1:0]           pick_idx;

    logic [DATA_W-1:0] cur_dout;
    logic              cur_empty;
    logic              cur_srst;
    logic [REM_W-1:0]  rem_eff;
    logic              beat_acc;
    logic              stalled;
    logic              rd_en;
    logic [1:0]        rd_idx;

    // A FIFO being flushed this cycle is not a valid candidate.
    assign req = ~{fifo_empty_2, fifo_empty_1, fifo_empty_0}
               & ~{soft_reset_2, soft_reset_1, soft_reset_0};

    router_rr_pick u_rr_pick (
        .req       (req),
        .last      (rr_ptr_q),
        .gnt_valid (pick_valid),
        .gnt_idx   (pick_idx)
    );

    // Select the granted FIFO; idle grant falls back to FIFO 0's data.
    always_comb begin : cur_mux
        case (grant_q)
            2'd1: begin
                cur_dout  = fifo_dout_1;
                cur_empty = fifo_empty_1;
                cur_srst  = soft_reset_1;
            end
            2'd2: begin
                cur_dout  = fifo_dout_2;
                cur_empty = fifo_empty_2;
                cur_srst  = soft_reset_2;
            end
            default: begin
                cur_dout  = fifo_dout_0;
                cur_empty = fifo_empty_0;
                cur_srst  = soft_reset_0;
            end
        endcase
    end

    assign beat_acc = valid_q & egress.ready;
    assign stalled  = valid_q & ~egress.ready;

    // While the header sits on the link the counter is taken straight from
    // it, so the first payload read can overlap header acceptance.
    assign rem_eff = (state_q == StHeader)
                   ? (REM_W'(hdr_len(cur_dout)) + REM_W'(1))
                   : remaining_q;

    // Next-state, read strobe and registered-output computation.
    always_comb begin : arb_next
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        grant_d     = grant_q;
        remaining_d = remaining_q;
        valid_d     = stalled;
        sop_d       = stalled & sop_q;
        eop_d       = stalled & eop_q;
        abort_d     = 1'b0;
        rd_en       = 1'b0;
        rd_idx      = grant_q;

        unique case (state_q)
            StIdle: begin
                if (pick_valid) begin
                    rd_en    = 1'b1;
                    rd_idx   = pick_idx;
                    rr_ptr_d = pick_idx;
                    grant_d  = pick_idx;
                    state_d  = StHeader;
                    valid_d  = 1'b1;
                    sop_d    = 1'b1;
                    eop_d    = 1'b0;
                end
            end

            StHeader, StBody: begin
                if (cur_srst) begin
                    // Flushed mid-packet: drop the link and report it.
                    state_d     = StIdle;
                    grant_d     = IDLE_GRANT;
                    remaining_d = '0;
                    valid_d     = 1'b0;
                    sop_d       = 1'b0;
                    eop_d       = 1'b0;
                    abort_d     = 1'b1;
                end else begin
                    if ((rem_eff != '0) && !cur_empty && (!valid_q || egress.ready)) begin
                        rd_en       = 1'b1;
                        valid_d     = 1'b1;
                        sop_d       = 1'b0;
                        eop_d       = (rem_eff == REM_W'(1));
                        remaining_d = rem_eff - REM_W'(1);
                    end else begin
                        remaining_d = rem_eff;
                    end

                    if (state_q == StHeader) begin
                        if (beat_acc) begin
                            state_d = StBody;
                        end
                    end else if (beat_acc && eop_q) begin
                        state_d = StIdle;
                        grant_d = IDLE_GRANT;
                    end
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and registered outputs, synchronous active-low reset.
    always_ff @(posedge clock) begin : arb_regs
        if (!resetn) begin
            state_q     <= StIdle;
            rr_ptr_q    <= RR_RESET;
            grant_q     <= IDLE_GRANT;
            remaining_q <= '0;
            valid_q     <= 1'b0;
            sop_q       <= 1'b0;
            eop_q       <= 1'b0;
            abort_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            grant_q     <= grant_d;
            remaining_q <= remaining_d;
            valid_q     <= valid_d;
            sop_q       <= sop_d;
            eop_q       <= eop_d;
            abort_q     <= abort_d;
        end
    end

    // Read strobes are combinational so the FIFO pops in the decision cycle;
    // hard reset suppresses them so nothing is lost while held in reset.
    assign read_enb_0 = resetn & rd_en & (rd_idx == 2'd0);
    assign read_enb_1 = resetn & rd_en & (rd_idx == 2'd1);
    assign read_enb_2 = resetn & rd_en & (rd_idx == 2'd2);

    assign grant        = grant_q;
    assign egress.data  = cur_dout;
    assign egress.valid = valid_q;
    assign egress.sop   = sop_q;
    assign egress.eop   = eop_q;
    assign egress.abort = abort_q;

endmodule

// File: tb/tb_router_egress_arb.sv
// Directed bench for router_egress_arb: three behavioural FIFOs, a beat log
// of accepted egress beats, and hand-computed expectations.
module tb_router_egress_arb;

    logic       clock = 1'b0;
    logic       resetn;
    logic       fifo_empty_0, fifo_empty_1, fifo_empty_2;
    logic [7:0] fifo_dout_0, fifo_dout_1, fifo_dout_2;
    logic       soft_reset_0, soft_reset_1, soft_reset_2;
    logic       read_enb_0, read_enb_1, read_enb_2;
    logic [1:0] grant;

    router_egress_arb_if eg_if ();

    router_egress_arb dut (
        .clock        (clock),
        .resetn       (resetn),
        .fifo_empty_0 (fifo_empty_0),
        .fifo_empty_1 (fifo_empty_1),
        .fifo_empty_2 (fifo_empty_2),
        .fifo_dout_0  (fifo_dout_0),
        .fifo_dout_1  (fifo_dout_1),
        .fifo_dout_2  (fifo_dout_2),
        .soft_reset_0 (soft_reset_0),
        .soft_reset_1 (soft_reset_1),
        .soft_reset_2 (soft_reset_2),
        .read_enb_0   (read_enb_0),
        .read_enb_1   (read_enb_1),
        .read_enb_2   (read_enb_2),
        .grant        (grant),
        .egress       (eg_if)
    );

    always #5 clock = ~clock;

    logic [7:0]  fq0[$];
    logic [7:0]  fq1[$];
    logic [7:0]  fq2[$];
    logic [11:0] beats[$];
    logic [11:0] exp_beats[$];
    int          n_checks;
    int          n_errors;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [11:0] bt(input logic [1:0] g, input logic s, input logic e,
                                       input logic [7:0] d);
        return {g, s, e, d};
    endfunction

    task automatic refresh_empty();
        fifo_empty_0 = (fq0.size() == 0);
        fifo_empty_1 = (fq1.size() == 0);
        fifo_empty_2 = (fq2.size() == 0);
    endtask

    task automatic push(input int k, input logic [7:0] b);
        case (k)
            0:       fq0.push_back(b);
            1:       fq1.push_back(b);
            default: fq2.push_back(b);
        endcase
        refresh_empty();
    endtask

    task automatic push_pkt(input int k, input logic [7:0] hdr, input int n_pay,
                            input logic [7:0] base, input logic [7:0] par);
        push(k, hdr);
        for (int i = 1; i <= n_pay; i++) push(k, base + 8'(i));
        push(k, par);
    endtask

    // One clock: log the accepted beat, then apply FIFO pops/flushes.
    task automatic cycle();
        logic [2:0] re;
        logic [2:0] sr;
        re = {read_enb_2, read_enb_1, read_enb_0};
        sr = {soft_reset_2, soft_reset_1, soft_reset_0};
        if (eg_if.valid && eg_if.ready) beats.push_back(bt(grant, eg_if.sop, eg_if.eop, eg_if.data));
        @(posedge clock);
        #1;
        if (sr[0]) fq0.delete(); else if (re[0] && fq0.size() > 0) fifo_dout_0 = fq0.pop_front();
        if (sr[1]) fq1.delete(); else if (re[1] && fq1.size() > 0) fifo_dout_1 = fq1.pop_front();
        if (sr[2]) fq2.delete(); else if (re[2] && fq2.size() > 0) fifo_dout_2 = fq2.pop_front();
        refresh_empty();
        @(negedge clock);
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        repeat (3) cycle();
        resetn = 1'b1;
        beats.delete();
    endtask

    task automatic check_beats(input string tag);
        check_eq({tag, "_count"}, beats.size(), exp_beats.size());
        for (int i = 0; i < beats.size() && i < exp_beats.size(); i++)
            check_eq($sformatf("%s%0d", tag, i), beats[i], exp_beats[i]);
        beats.delete();
        exp_beats.delete();
    endtask

    logic [15:0] t1_exp [7];
    logic [15:0] vtrace;
    logic [11:0] rdy3;
    logic [5:0]  t4_exp [3];

    initial begin
        n_checks     = 0;
        n_errors     = 0;
        resetn       = 1'b0;
        soft_reset_0 = 1'b0;
        soft_reset_1 = 1'b0;
        soft_reset_2 = 1'b0;
        eg_if.ready  = 1'b0;
        fifo_dout_0  = 8'hA5;
        fifo_dout_1  = 8'h5A;
        fifo_dout_2  = 8'hC3;
        refresh_empty();
        @(negedge clock);
        do_reset();
        #1;

        // Reset state
        check_eq("rst_valid", eg_if.valid, 1'b0);
        check_eq("rst_flags", {eg_if.sop, eg_if.eop, eg_if.abort}, 3'b000);
        check_eq("rst_grant", grant, 2'b11);
        check_eq("rst_rd", {read_enb_2, read_enb_1, read_enb_0}, 3'b000);
        check_eq("rst_data", eg_if.data, 8'hA5);

        // Single len-3 packet on FIFO 1; {rd[2:0], valid, sop, eop, grant, data}
        t1_exp = '{{3'b010, 3'b000, 2'd3, 8'hA5},
                   {3'b010, 3'b110, 2'd1, 8'h0D},
                   {3'b010, 3'b100, 2'd1, 8'h31},
                   {3'b010, 3'b100, 2'd1, 8'h32},
                   {3'b010, 3'b100, 2'd1, 8'h33},
                   {3'b000, 3'b101, 2'd1, 8'hE1},
                   {3'b000, 3'b000, 2'd3, 8'hA5}};
        eg_if.ready = 1'b1;
        push_pkt(1, 8'h0D, 3, 8'h30, 8'hE1);
        for (int i = 0; i < 7; i++) begin
            #1;
            check_eq($sformatf("t1_cyc%0d", i),
                     {read_enb_2, read_enb_1, read_enb_0, eg_if.valid, eg_if.sop, eg_if.eop,
                      grant, eg_if.data}, t1_exp[i]);
            cycle();
        end
        beats.delete();

        // Three len-2 packets after reset: order 0,1,2 with one bubble between
        do_reset();
        push_pkt(0, 8'h08, 2, 8'h00, 8'h0F);
        push_pkt(1, 8'h09, 2, 8'h10, 8'h1F);
        push_pkt(2, 8'h0A, 2, 8'h20, 8'h2F);
        vtrace = '0;
        for (int i = 0; i < 16; i++) begin
            #1;
            vtrace[i] = eg_if.valid;
            cycle();
        end
        check_eq("t2_valid_trace", vtrace, 16'h7BDE);
        exp_beats = '{bt(0, 1, 0, 8'h08), bt(0, 0, 0, 8'h01), bt(0, 0, 0, 8'h02),
                      bt(0, 0, 1, 8'h0F), bt(1, 1, 0, 8'h09), bt(1, 0, 0, 8'h11),
                      bt(1, 0, 0, 8'h12), bt(1, 0, 1, 8'h1F), bt(2, 1, 0, 8'h0A),
                      bt(2, 0, 0, 8'h21), bt(2, 0, 0, 8'h22), bt(2, 0, 1, 8'h2F)};
        check_beats("t2_beat");

        // len-4 packet on FIFO 0 with ready low for cycles 3..5
        rdy3 = 12'hFC7;
        push_pkt(0, 8'h10, 4, 8'h40, 8'h4F);
        for (int i = 0; i < 12; i++) begin
            eg_if.ready = rdy3[i];
            #1;
            if (i >= 3 && i <= 5)
                check_eq($sformatf("t3_stall%0d", i),
                         {read_enb_2, read_enb_1, read_enb_0, eg_if.valid, eg_if.data},
                         {3'b000, 1'b1, 8'h42});
            cycle();
        end
        eg_if.ready = 1'b1;
        exp_beats = '{bt(0, 1, 0, 8'h10), bt(0, 0, 0, 8'h41), bt(0, 0, 0, 8'h42),
                      bt(0, 0, 0, 8'h43), bt(0, 0, 0, 8'h44), bt(0, 0, 1, 8'h4F)};
        check_beats("t3_beat");

        // len-5 packet on FIFO 2 that runs dry after two payload bytes
        t4_exp = '{{3'b000, 1'b1, 2'd2}, {3'b000, 1'b0, 2'd2}, {3'b000, 1'b0, 2'd2}};
        push(2, 8'h16);
        push(2, 8'h51);
        push(2, 8'h52);
        for (int i = 0; i < 13; i++) begin
            if (i == 6) begin
                push(2, 8'h53);
                push(2, 8'h54);
                push(2, 8'h55);
                push(2, 8'h5F);
            end
            #1;
            if (i >= 3 && i <= 5)
                check_eq($sformatf("t4_dry%0d", i),
                         {read_enb_2, read_enb_1, read_enb_0, eg_if.valid, grant},
                         t4_exp[i-3]);
            if (i == 6)
                check_eq("t4_resume",
                         {read_enb_2, read_enb_1, read_enb_0, eg_if.valid, grant},
                         {3'b100, 1'b0, 2'd2});
            cycle();
        end
        exp_beats = '{bt(2, 1, 0, 8'h16), bt(2, 0, 0, 8'h51), bt(2, 0, 0, 8'h52),
                      bt(2, 0, 0, 8'h53), bt(2, 0, 0, 8'h54), bt(2, 0, 0, 8'h55),
                      bt(2, 0, 1, 8'h5F)};
        check_beats("t4_beat");

        // Soft reset of FIFO 0 mid-body, then a len-0 packet from FIFO 1
        push_pkt(0, 8'h0C, 3, 8'h60, 8'h6F);
        push_pkt(1, 8'h01, 0, 8'h00, 8'h7F);
        for (int i = 0; i < 8; i++) begin
            if (i == 3) soft_reset_0 = 1'b1;
            if (i == 4) soft_reset_0 = 1'b0;
            #1;
            if (i == 3)
                check_eq("t5_pre_abort",
                         {eg_if.abort, eg_if.valid, read_enb_2, read_enb_1, read_enb_0},
                         {1'b0, 1'b1, 3'b000});
            if (i == 4)
                check_eq("t5_abort",
                         {eg_if.abort, eg_if.valid, grant, read_enb_2, read_enb_1, read_enb_0},
                         {1'b1, 1'b0, 2'd3, 3'b010});
            if (i == 5)
                check_eq("t5_after_abort", {eg_if.abort, eg_if.valid, eg_if.sop, grant},
                         {1'b0, 1'b1, 1'b1, 2'd1});
            cycle();
        end
        exp_beats = '{bt(0, 1, 0, 8'h0C), bt(0, 0, 0, 8'h61), bt(0, 0, 0, 8'h62),
                      bt(1, 1, 0, 8'h01), bt(1, 0, 1, 8'h7F)};
        check_beats("t5_beat");

        // Hard reset mid-packet: no abort, link dropped, no reads while held
        push_pkt(0, 8'h08, 2, 8'h80, 8'h8F);
        for (int i = 0; i < 6; i++) begin
            if (i == 2) begin
                resetn       = 1'b0;
                soft_reset_0 = 1'b1;
            end
            if (i == 3) soft_reset_0 = 1'b0;
            #1;
            if (i == 2)
                check_eq("t7_rd_gated", {read_enb_2, read_enb_1, read_enb_0}, 3'b000);
            if (i == 3) begin
                check_eq("t7_hard_rst",
                         {eg_if.abort, eg_if.valid, eg_if.sop, eg_if.eop, grant},
                         {4'b0000, 2'd3});
                resetn = 1'b1;
            end
            if (i == 4)
                check_eq("t7_post",
                         {eg_if.abort, eg_if.valid, read_enb_2, read_enb_1, read_enb_0},
                         5'b00000);
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
